// File: rtl/moore_seq_detector_pkg.sv
// Shared definitions for the serial sequence detector.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents: state width helper st_w(), the maximum supported pattern length,
// and the state vector type. The state type is sized for the maximum pattern
// length so the combinational fallback calculator has one fixed port width.
package moore_seq_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int MAX_ST_W    = $clog2(MAX_PAT_LEN + 1);

    // Bits needed to encode S0..S_pat_len.
    function automatic int st_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    typedef logic [MAX_ST_W-1:0] state_t;

endpackage

// File: rtl/moore_seq_detector_if.sv
// Bundle of serial-bit input, pattern programming and match outputs.
// Latency: n/a (wires only).
// Backpressure: none; in_valid qualifies each bit and the detector always accepts.
//
// Signals:
//   in_valid     qualifies in
//   in           serial data bit
//   pat_load     load pat_in into the pattern register
//   pat_in       new pattern, MSB is the first bit expected
//   out          one-cycle-per-match flag (held while no new valid bit)
//   match_count  saturating match counter (0 when the counter is compiled out)
interface moore_seq_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);

    logic               in_valid;
    logic               in;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               out;
    logic [CNT_W-1:0]   match_count;

    // Bit source / control side.
    modport master (
        output in_valid,
        output in,
        output pat_load,
        output pat_in,
        input  out,
        input  match_count
    );

    // Detector side.
    modport slave (
        input  in_valid,
        input  in,
        input  pat_load,
        input  pat_in,
        output out,
        output match_count
    );

endinterface

// File: rtl/moore_seq_detector_next_state.sv
// Combinational KMP-style fallback: longest pattern prefix that is a suffix of (matched prefix, new bit).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//
// Ports:
//   pattern  live pattern register, MSB is the first bit expected
//   state    number of pattern bits currently matched
//   din      incoming serial bit
//   overlap  1: keep history after a full match; 0: restart from empty
//   nxt      next matched length
module moore_seq_detector_next_state
    import moore_seq_pkg::*;
#(
    parameter int PAT_LEN = 4
) (
    input  logic [PAT_LEN-1:0] pattern,
    input  state_t             state,
    input  logic               din,
    input  logic               overlap,
    output state_t             nxt
);

    localparam int VW = MAX_PAT_LEN + 1;

    logic [VW-1:0] pat_ext;
    logic [VW-1:0] hist;
    logic [VW-1:0] head;
    logic [VW-1:0] mask;
    int            k_len;

    always_comb begin
        pat_ext = '0;
        pat_ext[PAT_LEN-1:0] = pattern;

        // A completed match without overlap behaves as if nothing was matched.
        if (state == state_t'(PAT_LEN) && !overlap) begin
            k_len = 0;
        end else begin
            k_len = int'(state);
        end

        // History as a number with the newest bit at the LSB: the first k_len
        // pattern bits followed by din. Bits above k_len+1 are zero.
        hist = ((pat_ext >> (PAT_LEN - k_len)) << 1) | {{(VW-1){1'b0}}, din};

        head = '0;
        mask = '0;
        nxt  = '0;
        // Ascending scan: the last hit is the longest valid prefix.
        for (int j = 1; j <= PAT_LEN; j++) begin
            head = pat_ext >> (PAT_LEN - j);
            mask = ~({VW{1'b1}} << j);
            // j may not exceed the real history length, otherwise the zero
            // padding above the history could fake a match.
            if ((j <= k_len + 1) && ((hist & mask) == head)) begin
                nxt = state_t'(j);
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with runtime-programmable pattern and optional saturating match counter.
// Latency: last pattern bit sampled at edge N -> out high in the cycle after edge N (registered, no in->out path).
// Backpressure: none; bits are accepted whenever in_valid is high, state holds while it is low.
//
// Ports: clk (rising edge), rst (async, active low), bus (moore_seq_detector_if.slave:
//   in_valid, in, pat_load, pat_in -> out, match_count).
// Edge priority: rst > pat_load > in_valid. A pat_load edge clears the state and ignores in.
// Build option: define MOORE_SEQ_MATCH_CNT_EN to implement match_count; otherwise it is tied to 0.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    moore_seq_detector_if.slave  bus
);

    localparam int ST_W = st_w(PAT_LEN);

    logic [PAT_LEN-1:0] pattern_q;
    logic [ST_W-1:0]    state_q;
    logic [ST_W-1:0]    state_d;
    logic               out_q;
    logic               out_d;
    state_t             state_ext;
    state_t             state_nxt;
    logic               adv;
    logic               hit;

    assign state_ext = state_t'(state_q);
    assign adv       = bus.in_valid && !bus.pat_load;
    assign hit       = (state_nxt == state_t'(PAT_LEN));

    moore_seq_detector_next_state #(
        .PAT_LEN (PAT_LEN)
    ) u_next (
        .pattern (pattern_q),
        .state   (state_ext),
        .din     (bus.in),
        .overlap (OVERLAP),
        .nxt     (state_nxt)
    );

    // Pattern register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= PATTERN;
        end else if (bus.pat_load) begin
            pattern_q <= bus.pat_in;
        end
    end

    // FSM: next state and registered match flag.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (bus.pat_load) begin
            state_d = '0;
            out_d   = 1'b0;
        end else if (bus.in_valid) begin
            state_d = ST_W'(state_nxt);
            out_d   = hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.out = out_q;

`ifdef MOORE_SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts every entry into the full-match state, including full->full
    // for self-overlapping patterns; sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (adv && hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt      = adv ^ hit;
    assign bus.match_count = '0;
`endif

endmodule
